// File: rtl/video_pkg.sv
// -----------------------------------------------------------------------------
// video_pkg
// Definitions shared by the sprite motion controller and its sub-module:
//   - playfield and sprite geometry defaults
//   - bit positions inside the 4-bit collision vector from the merge stage
//   - the per-frame update FSM state encoding
//   - the per-axis direction type, the latched button record, and a helper
//     that turns two opposing buttons and two blocking flags into an intent
// -----------------------------------------------------------------------------
package video_pkg;

  localparam int SPRITE_SIZE = 16;
  localparam int BG_SIZE_X   = 1000;
  localparam int BG_SIZE_Y   = 1000;

  // Width of a sprite coordinate.
  localparam int POS_W = 10;

  // Bit positions in the collision vector.
  localparam int COL_RIGHT  = 0;
  localparam int COL_LEFT   = 1;
  localparam int COL_BOTTOM = 2;
  localparam int COL_TOP    = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SAMPLE = 3'd1,
    ST_MOVE_X = 3'd2,
    ST_MOVE_Y = 3'd3,
    ST_DONE   = 3'd4
  } motion_state_t;

  // Direction of travel on one axis. POS is towards larger coordinates
  // (right on X, down on Y).
  typedef enum logic [1:0] {
    DIR_NONE = 2'b00,
    DIR_POS  = 2'b01,
    DIR_NEG  = 2'b10
  } dir_t;

  typedef struct packed {
    logic up;
    logic down;
    logic left;
    logic right;
  } buttons_t;

  // Opposing buttons cancel out; a direction into a wall that the merge
  // stage reports as touching is suppressed.
  function automatic dir_t axis_intent(input logic pos_btn,
                                       input logic neg_btn,
                                       input logic pos_blocked,
                                       input logic neg_blocked);
    dir_t d;
    d = DIR_NONE;
    if (pos_btn && !neg_btn && !pos_blocked)
      d = DIR_POS;
    else if (neg_btn && !pos_btn && !neg_blocked)
      d = DIR_NEG;
    return d;
  endfunction

endpackage

// File: rtl/sprite_motion_ctrl_axis_step.sv
// -----------------------------------------------------------------------------
// axis_step
// Combinational next-position calculation for one axis.
//   pos      current coordinate
//   dir      DIR_POS / DIR_NEG / DIR_NONE
//   step     step size in pixels (1..15)
//   limit    largest legal coordinate on this axis
//   next_pos coordinate after the step, clamped to [0, limit]
// The sum is formed one bit wider than the coordinate so that a step past
// the far edge is caught before it can wrap.
// -----------------------------------------------------------------------------
module axis_step
  import video_pkg::*;
(
  input  logic [POS_W-1:0] pos,
  input  dir_t             dir,
  input  logic [3:0]       step,
  input  logic [POS_W-1:0] limit,
  output logic [POS_W-1:0] next_pos
);

  logic [POS_W:0] wide_pos;
  logic [POS_W:0] wide_step;
  logic [POS_W:0] wide_limit;
  logic [POS_W:0] sum;

  assign wide_pos   = {1'b0, pos};
  assign wide_step  = (POS_W + 1)'(step);
  assign wide_limit = {1'b0, limit};
  assign sum        = wide_pos + wide_step;

  // NOTE: next_pos gets a default before the case so every path assigns it
  // and no latch is inferred.
  always_comb begin
    next_pos = pos;
    case (dir)
      DIR_POS: next_pos = (sum > wide_limit) ? limit : sum[POS_W-1:0];
      DIR_NEG: next_pos = (wide_pos < wide_step) ? '0 : pos - POS_W'(step);
      default: next_pos = pos;
    endcase
  end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// -----------------------------------------------------------------------------
// sprite_motion_ctrl
// Once per video frame, samples the direction buttons and the collision
// flags, updates the step size (accelerating while a move is possible,
// falling back to 1 otherwise) and moves the sprite origin one axis per
// cycle, clamped to the playfield. Positions only change inside the
// update sequence, so the merge stage sees a stable origin for a frame.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   frame_start                one-cycle pulse at start of vertical blank
//   enable                     frames are ignored while low
//   btn_up/down/left/right     debounced button levels
//   collision[3:0]             {top, bottom, left, right} contact flags
//   posX_sp, posY_sp           sprite origin
//   speed                      step size used by the latest update
//   moving                     latest update changed X or Y
//   update_done                one-cycle pulse, new position is valid
//
// Sequence after frame_start in IDLE at cycle N:
//   N+1 SAMPLE  latch inputs, new speed
//   N+2 MOVE_X  posX_sp updated on the closing edge
//   N+3 MOVE_Y  posY_sp updated on the closing edge
//   N+4 DONE    update_done high
// frame_start outside IDLE is dropped.
// -----------------------------------------------------------------------------
module sprite_motion_ctrl #(
  parameter int SPRITE_SIZE = video_pkg::SPRITE_SIZE,
  parameter int BG_SIZE_X   = video_pkg::BG_SIZE_X,
  parameter int BG_SIZE_Y   = video_pkg::BG_SIZE_Y,
  parameter int X_INIT      = 492,
  parameter int Y_INIT      = 492,
  parameter int MAX_STEP    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_start,
  input  logic       enable,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic [3:0] collision,
  output logic [9:0] posX_sp,
  output logic [9:0] posY_sp,
  output logic [3:0] speed,
  output logic       moving,
  output logic       update_done
);

  import video_pkg::*;

  localparam logic [POS_W-1:0] X_MAX    = POS_W'(BG_SIZE_X - SPRITE_SIZE);
  localparam logic [POS_W-1:0] Y_MAX    = POS_W'(BG_SIZE_Y - SPRITE_SIZE);
  localparam logic [POS_W-1:0] X_RESET  = POS_W'(X_INIT);
  localparam logic [POS_W-1:0] Y_RESET  = POS_W'(Y_INIT);
  localparam logic [3:0]       STEP_MAX = 4'(MAX_STEP);

  motion_state_t    state;
  buttons_t         btn_q;
  logic [3:0]       col_q;
  logic             x_moved;

  dir_t             live_dx;
  dir_t             live_dy;
  dir_t             dir_x;
  dir_t             dir_y;
  logic [3:0]       next_speed;
  logic [POS_W-1:0] x_next;
  logic [POS_W-1:0] y_next;

  // Intent from the live inputs decides the speed for this frame while the
  // inputs are being latched; the move states then work from the latched
  // copy so later input changes cannot disturb an update in progress.
  assign live_dx = axis_intent(btn_right, btn_left,
                               collision[COL_RIGHT], collision[COL_LEFT]);
  assign live_dy = axis_intent(btn_down, btn_up,
                               collision[COL_BOTTOM], collision[COL_TOP]);

  assign dir_x = axis_intent(btn_q.right, btn_q.left,
                             col_q[COL_RIGHT], col_q[COL_LEFT]);
  assign dir_y = axis_intent(btn_q.down, btn_q.up,
                             col_q[COL_BOTTOM], col_q[COL_TOP]);

  always_comb begin
    next_speed = 4'd1;
    if (live_dx != DIR_NONE || live_dy != DIR_NONE)
      next_speed = (speed >= STEP_MAX) ? STEP_MAX : speed + 4'd1;
  end

  axis_step u_step_x (
    .pos      (posX_sp),
    .dir      (dir_x),
    .step     (speed),
    .limit    (X_MAX),
    .next_pos (x_next)
  );

  axis_step u_step_y (
    .pos      (posY_sp),
    .dir      (dir_y),
    .step     (speed),
    .limit    (Y_MAX),
    .next_pos (y_next)
  );

  // NOTE: all state and registered outputs use non-blocking assignments so
  // every right-hand side sees the values from before this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      btn_q       <= '0;
      col_q       <= '0;
      x_moved     <= 1'b0;
      posX_sp     <= X_RESET;
      posY_sp     <= Y_RESET;
      speed       <= 4'd1;
      moving      <= 1'b0;
      update_done <= 1'b0;
    end else begin
      update_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (frame_start && enable)
            state <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          btn_q <= '{up: btn_up, down: btn_down, left: btn_left, right: btn_right};
          col_q <= collision;
          speed <= next_speed;
          state <= ST_MOVE_X;
        end
        ST_MOVE_X: begin
          posX_sp <= x_next;
          x_moved <= (x_next != posX_sp);
          state   <= ST_MOVE_Y;
        end
        ST_MOVE_Y: begin
          posY_sp     <= y_next;
          moving      <= x_moved || (y_next != posY_sp);
          update_done <= 1'b1;
          state       <= ST_DONE;
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sprite_motion_ctrl
// Directed and randomized frames against a plain-arithmetic model of the
// sprite motion rules (intent, blocking, acceleration, clamping).
// Button vectors in this bench are {up, down, left, right}.
// -----------------------------------------------------------------------------
module tb_sprite_motion_ctrl;

  localparam int LIM_X = 984;
  localparam int LIM_Y = 984;
  localparam int INIT  = 492;
  localparam int SMAX  = 8;

  localparam logic [3:0] B_R = 4'b0001;
  localparam logic [3:0] B_L = 4'b0010;
  localparam logic [3:0] B_D = 4'b0100;
  localparam logic [3:0] B_U = 4'b1000;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_start;
  logic       enable;
  logic       btn_up, btn_down, btn_left, btn_right;
  logic [3:0] collision;
  logic [9:0] posX_sp, posY_sp;
  logic [3:0] speed;
  logic       moving;
  logic       update_done;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state.
  int m_x, m_y, m_speed;
  bit m_moving;

  always #5 clk = ~clk;

  sprite_motion_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .enable      (enable),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .collision   (collision),
    .posX_sp     (posX_sp),
    .posY_sp     (posY_sp),
    .speed       (speed),
    .moving      (moving),
    .update_done (update_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clamp(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic model_reset();
    m_x = INIT; m_y = INIT; m_speed = 1; m_moving = 1'b0;
  endtask

  task automatic model_frame(input logic [3:0] b, input logic [3:0] c);
    int dx, dy, nx, ny;
    dx = int'(b[0]) - int'(b[1]);
    dy = int'(b[2]) - int'(b[3]);
    if (dx == 1 && c[0]) dx = 0;
    if (dx == -1 && c[1]) dx = 0;
    if (dy == 1 && c[2]) dy = 0;
    if (dy == -1 && c[3]) dy = 0;
    if (dx != 0 || dy != 0) m_speed = (m_speed + 1 > SMAX) ? SMAX : m_speed + 1;
    else m_speed = 1;
    nx = clamp(m_x + dx * m_speed, 0, LIM_X);
    ny = clamp(m_y + dy * m_speed, 0, LIM_Y);
    m_moving = (nx != m_x) || (ny != m_y);
    m_x = nx;
    m_y = ny;
  endtask

  task automatic drive_inputs(input logic [3:0] b, input logic [3:0] c);
    {btn_up, btn_down, btn_left, btn_right} = b;
    collision = c;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".x"}, posX_sp, m_x);
    check({tag, ".y"}, posY_sp, m_y);
    check({tag, ".speed"}, speed, m_speed);
    check({tag, ".moving"}, moving, m_moving);
  endtask

  // One complete frame update; inputs are scrambled once SAMPLE has passed.
  task automatic run_frame(input logic [3:0] b, input logic [3:0] c, input string tag);
    int old_y;
    int done_at;
    old_y = m_y;
    model_frame(b, c);
    @(negedge clk);
    drive_inputs(b, c);
    frame_start = 1'b1;
    @(negedge clk);                       // cycle N+1
    frame_start = 1'b0;
    @(negedge clk);                       // cycle N+2
    drive_inputs(4'($urandom), 4'($urandom));
    done_at = -1;
    for (int k = 2; k <= 10; k++) begin
      if (k == 3) begin
        check({tag, ".x_at_n3"}, posX_sp, m_x);
        check({tag, ".y_at_n3"}, posY_sp, old_y);
      end
      if (update_done === 1'b1) begin
        done_at = k;
        break;
      end
      @(negedge clk);
    end
    check({tag, ".done_cycle"}, done_at, 4);
    check_state(tag);
    @(negedge clk);
    check({tag, ".done_pulse"}, update_done, 1'b0);
    drive_inputs(4'b0, 4'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_done;
    int guard;
    reset = 1'b1; frame_start = 1'b0; enable = 1'b1;
    drive_inputs(4'b0, 4'b0);
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_state("reset");
    check("reset.done", update_done, 1'b0);

    // Idle frame.
    run_frame(4'b0, 4'b0, "idle");

    // Acceleration to the ceiling.
    for (int i = 0; i < 10; i++) run_frame(B_R, 4'b0, "accel");
    check("accel.speed_cap", speed, SMAX);

    // Drive to the right edge, then step back to 982.
    guard = 0;
    while (m_x != LIM_X && guard < 80) begin
      run_frame(B_R, 4'b0, "to_right");
      guard++;
    end
    check("right_edge.x", posX_sp, LIM_X);
    run_frame(B_R, 4'b0, "right_clamp");
    run_frame(4'b0, 4'b0, "blank1");
    run_frame(B_L, 4'b0, "left2");
    check("x982", posX_sp, 982);
    run_frame(B_R, 4'b0001, "right_blocked");
    check("blocked.x", posX_sp, 982);
    check("blocked.speed", speed, 1);
    check("blocked.moving", moving, 1'b0);

    // Run left to the wall, then set up X=3 and overshoot at speed 5.
    guard = 0;
    while (m_x != 0 && guard < 200) begin
      run_frame(B_L, 4'b0, "to_left");
      guard++;
    end
    run_frame(4'b0, 4'b0, "blank2");
    run_frame(B_D, 4'b0, "down_s2");
    run_frame(B_R, 4'b0, "right_s3");
    check("x3", posX_sp, 3);
    run_frame(B_D, 4'b0, "down_s4");
    run_frame(B_L, 4'b0, "left_s5");
    check("left_clamp.x", posX_sp, 0);
    check("left_clamp.speed", speed, 5);
    run_frame(B_L, 4'b0010, "left_blocked");
    check("left_blocked.x", posX_sp, 0);

    // Opposing horizontal buttons with down held.
    run_frame(B_L | B_R | B_D, 4'b0, "lr_down");

    // frame_start while disabled is ignored.
    enable = 1'b0;
    @(negedge clk); drive_inputs(B_R, 4'b0); frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
    n_done = 0;
    for (int k = 0; k < 8; k++) begin
      if (update_done === 1'b1) n_done++;
      @(negedge clk);
    end
    check("disabled.done_count", n_done, 0);
    check_state("disabled");
    enable = 1'b1;
    drive_inputs(4'b0, 4'b0);

    // Second frame_start during MOVE_Y is dropped.
    model_frame(B_U, 4'b0);
    @(negedge clk); drive_inputs(B_U, 4'b0); frame_start = 1'b1;   // N
    @(negedge clk); frame_start = 1'b0;                             // N+1
    @(negedge clk);                                                 // N+2
    @(negedge clk); frame_start = 1'b1;                             // N+3
    n_done = 0;
    for (int k = 0; k < 12; k++) begin
      if (update_done === 1'b1) n_done++;
      @(negedge clk);
      frame_start = 1'b0;
    end
    check("drop.done_count", n_done, 1);
    check_state("drop");
    drive_inputs(4'b0, 4'b0);

    // Reset during MOVE_X discards the update.
    @(negedge clk); drive_inputs(B_R, 4'b0); frame_start = 1'b1;   // N
    @(negedge clk); frame_start = 1'b0;                             // N+1
    @(negedge clk); reset = 1'b1;                                   // N+2
    @(negedge clk); reset = 1'b0;
    model_reset();
    check_state("mid_reset");
    n_done = 0;
    for (int k = 0; k < 8; k++) begin
      if (update_done === 1'b1) n_done++;
      @(negedge clk);
    end
    check("mid_reset.done_count", n_done, 0);
    check("mid_reset.x_hold", posX_sp, INIT);
    drive_inputs(4'b0, 4'b0);

    // Randomized frames with random gaps.
    for (int i = 0; i < 40; i++) begin
      logic [3:0] rb, rc;
      rb = 4'($urandom);
      rc = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_frame(rb, rc, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
